pad_input_conditioner: RTL and testbench
========================================

Name: pad_input_conditioner

Overview:
Parametrised input-conditioning stage that sits between the pad frame's raw io_in outputs and the SoC pad mux / GPIO logic. Per pad it provides:
- a multi-stage synchroniser
- an optional debounce/glitch filter with programmable length
- edge detection with selectable mode
- sticky per-pad event flags with clear, plus an aggregated interrupt

It generalises the fixed pass-through input path to N_IO channels with per-channel mode control.

Parameters:
N_IO, 61, number of pad channels
SYNC_STAGES, 2, synchroniser flops per pad (>=2)
DEBOUNCE_W, 8, width of debounce counter and threshold

Ports:
clk_i  in  1  SoC clock
rst_ni  in  1  asynchronous active-low reset
io_in_i  in  N_IO  raw data from pad frame (asynchronous)
filt_en_i  in  N_IO  per-pad debounce enable
edge_mode_i  in  N_IO x 2  per-pad edge select: 00 none, 01 rising, 10 falling, 11 both
debounce_len_i  in  DEBOUNCE_W  global threshold D, in consecutive stable cycles
event_clr_i  in  N_IO  per-pad event clear, level-sampled each cycle
irq_mask_i  in  N_IO  per-pad interrupt enable
io_in_o  out  N_IO  conditioned (synchronised, filtered) pad value
event_o  out  N_IO  sticky edge-event flags
irq_o  out  1  OR of (event_o & irq_mask_i)

Behaviour:
Reset (rst_ni low, asynchronous):
- All synchroniser flops, filtered values, previous-value registers, counters and event flags go to 0.
- io_in_o = 0, event_o = 0, irq_o = 0.

Synchroniser:
- SYNC_STAGES-deep shift chain per pad; sync output is s.

Filter, per pad, registers filt and cnt:
- Bypass applies when filt_en_i = 0 or debounce_len_i = 0: filt <= s each cycle; cnt <= 0.
- Filter otherwise:
  - if s == filt: cnt <= 0.
  - else if cnt == D-1: filt <= s, cnt <= 0.
  - else: cnt <= cnt + 1.
- filt updates only after D consecutive mismatch cycles. Any glitch shorter than D sync cycles resets the count and is suppressed.
- cnt saturates logically: it never exceeds D-1, and no wrap is possible.
- If D is reduced below the current cnt mid-operation, the next mismatch cycle with cnt >= D-1 updates filt (compare is >=, not ==).
- Toggling filt_en_i clears cnt on the next cycle. filt is unchanged by the toggle itself.
- io_in_o = filt.

Latency from a pad transition to io_in_o:
- SYNC_STAGES + max(D,1) clock cycles (filter enabled).
- SYNC_STAGES + 1 (bypass).

Edge detection:
- prev <= filt every cycle.
- rise = filt & ~prev; fall = ~filt & prev.
- hit = (mode[0] & rise) | (mode[1] & fall), using edge_mode_i in the same cycle.
- A mode change takes effect the cycle it is applied; it is not retroactive.
- A pad that is high at reset release produces a rising edge once filt first goes high. This is intended and documented for software.

Event flags:
- event <= (event & ~event_clr_i) | hit.
- Simultaneous hit and clear on the same pad: set wins, flag stays 1.
- Clear held high: the flag stays 0 except in cycles with hit.
- The flag is visible on event_o the cycle after the edge appears on io_in_o.

Interrupt:
- irq_o = |(event & irq_mask_i), combinational from registers only; no path from io_in_i.
- Masking does not clear events.

Reset mid-operation:
- Pending counts are discarded and events are lost.
- After release, behaviour is as from power-up.

Test Plan:
- Bypass latency: filt_en=0, SYNC_STAGES=2; pad0 0->1 at cycle 0 -> io_in_o[0]=1 at cycle 3; with mode=01, event_o[0]=1 at cycle 4; with mask=1, irq_o=1 at cycle 4.
- Debounce accept: D=5, filter on; pad3 high for 5 sync cycles -> io_in_o[3] rises at cycle 2+5=7. Glitch high for 4 cycles -> io_in_o[3] stays 0, cnt back to 0.
- Edge modes: pad7 toggled 0->1->0 with mode 01, 10, 11, 00 in turn -> events set on rise only, fall only, both (one flag, sticky), none respectively. Clear between runs.
- Set/clear collision: assert event_clr_i[5] in the exact cycle a rising hit occurs -> event_o[5]=1 next cycle. Clear alone the cycle after -> event_o[5]=0.
- Multi-channel / irq: pads 0, 30 and 60 each receive an edge; irq_mask=only bit 30 -> irq_o follows event_o[30] only. Clearing pad 30 -> irq_o=0 while event_o[0] and event_o[60] remain 1.
- Reset mid-count: D=200, pad mismatched for 100 cycles, then rst_ni pulsed low asynchronously (no clock edge) -> io_in_o, event_o and irq_o go 0 immediately. After release, a full 200-cycle stable input is required before the update.

Source files
------------

// File: rtl/pad_input_conditioner_if.sv
// Pad-frame to SoC conditioning bus: raw pad data and per-pad controls in,
// conditioned values, sticky edge events and the aggregated interrupt out.
interface pad_input_conditioner_if #(
  parameter int unsigned N_IO       = 61,
  parameter int unsigned DEBOUNCE_W = 8
);
  logic [N_IO-1:0]       io_in_i;
  logic [N_IO-1:0]       filt_en_i;
  logic [N_IO-1:0][1:0]  edge_mode_i;
  logic [DEBOUNCE_W-1:0] debounce_len_i;
  logic [N_IO-1:0]       event_clr_i;
  logic [N_IO-1:0]       irq_mask_i;
  logic [N_IO-1:0]       io_in_o;
  logic [N_IO-1:0]       event_o;
  logic                  irq_o;

  modport master (
    output io_in_i, filt_en_i, edge_mode_i, debounce_len_i, event_clr_i, irq_mask_i,
    input  io_in_o, event_o, irq_o
  );

  modport slave (
    input  io_in_i, filt_en_i, edge_mode_i, debounce_len_i, event_clr_i, irq_mask_i,
    output io_in_o, event_o, irq_o
  );
endinterface

// File: rtl/pad_input_conditioner.sv
// Per-pad input conditioning: synchroniser, optional debounce filter, edge
// detection into sticky event flags, and a masked OR-reduced interrupt.
module pad_input_conditioner #(
  parameter int unsigned N_IO        = 61,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE_W  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  pad_input_conditioner_if.slave   bus
);

  logic [N_IO-1:0]       sync_q [SYNC_STAGES];
  logic [N_IO-1:0]       s;
  logic [N_IO-1:0]       filt_q, filt_d;
  logic [N_IO-1:0]       prev_q;
  logic [N_IO-1:0]       event_q, event_d;
  logic [N_IO-1:0]       hit;
  logic [DEBOUNCE_W-1:0] cnt_q [N_IO];
  logic [DEBOUNCE_W-1:0] cnt_d [N_IO];
  logic [DEBOUNCE_W-1:0] len_m1;
  logic                  len_zero;

  assign s        = sync_q[SYNC_STAGES-1];
  assign len_zero = (bus.debounce_len_i == '0);
  assign len_m1   = bus.debounce_len_i - DEBOUNCE_W'(1);

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < N_IO; i++) begin
      cnt_d[i] = '0;
      if (!bus.filt_en_i[i] || len_zero) begin
        filt_d[i] = s[i];
      end else if (s[i] != filt_q[i]) begin
        // >= so that shrinking the threshold mid-count still lets the update through
        if (cnt_q[i] >= len_m1) begin
          filt_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DEBOUNCE_W'(1);
        end
      end
    end
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_IO; i++) begin
      hit[i] = (bus.edge_mode_i[i][0] & filt_q[i] & ~prev_q[i]) |
               (bus.edge_mode_i[i][1] & ~filt_q[i] & prev_q[i]);
    end
    // Set wins over a simultaneous clear
    event_d = (event_q & ~bus.event_clr_i) | hit;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < N_IO; i++) begin
        cnt_q[i] <= '0;
      end
      filt_q  <= '0;
      prev_q  <= '0;
      event_q <= '0;
    end else begin
      sync_q[0] <= bus.io_in_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      for (int i = 0; i < N_IO; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      filt_q  <= filt_d;
      prev_q  <= filt_q;
      event_q <= event_d;
    end
  end

  assign bus.io_in_o = filt_q;
  assign bus.event_o = event_q;
  assign bus.irq_o   = |(event_q & bus.irq_mask_i);

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Directed bench for pad_input_conditioner: latency, debounce, edge modes,
// set/clear collision, multi-channel interrupt masking and asynchronous reset.
module tb_pad_input_conditioner;
  localparam int unsigned N_IO = 61;
  localparam int unsigned DW   = 8;

  localparam logic [N_IO-1:0] B0  = 61'd1;
  localparam logic [N_IO-1:0] B3  = 61'd1 << 3;
  localparam logic [N_IO-1:0] B5  = 61'd1 << 5;
  localparam logic [N_IO-1:0] B7  = 61'd1 << 7;
  localparam logic [N_IO-1:0] B30 = 61'd1 << 30;
  localparam logic [N_IO-1:0] B60 = 61'd1 << 60;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pad_input_conditioner_if #(.N_IO(N_IO), .DEBOUNCE_W(DW)) bus ();

  pad_input_conditioner #(
    .N_IO        (N_IO),
    .SYNC_STAGES (2),
    .DEBOUNCE_W  (DW)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.io_in_i        = '0;
    bus.filt_en_i      = '0;
    bus.edge_mode_i    = '0;
    bus.debounce_len_i = '0;
    bus.event_clr_i    = '0;
    bus.irq_mask_i     = '0;
    tick(3);
    chk("reset_io_in", 64'(bus.io_in_o), 64'd0);
    chk("reset_event", 64'(bus.event_o), 64'd0);
    chk("reset_irq",   64'(bus.irq_o),   64'd0);
    rst_n = 1'b1;
    tick(2);

    // Bypass latency on pad 0
    bus.edge_mode_i[0] = 2'b01;
    bus.irq_mask_i     = B0;
    bus.io_in_i[0]     = 1'b1;
    tick(2);
    chk("byp_io_c2", 64'(bus.io_in_o), 64'd0);
    tick(1);
    chk("byp_io_c3",  64'(bus.io_in_o), 64'(B0));
    chk("byp_ev_c3",  64'(bus.event_o), 64'd0);
    chk("byp_irq_c3", 64'(bus.irq_o),   64'd0);
    tick(1);
    chk("byp_ev_c4",  64'(bus.event_o), 64'(B0));
    chk("byp_irq_c4", 64'(bus.irq_o),   64'd1);
    bus.event_clr_i[0] = 1'b1;
    tick(1);
    bus.event_clr_i[0] = 1'b0;
    chk("byp_clr_ev",  64'(bus.event_o), 64'd0);
    chk("byp_clr_irq", 64'(bus.irq_o),   64'd0);
    bus.io_in_i[0] = 1'b0;
    tick(4);
    chk("byp_fall_io", 64'(bus.io_in_o), 64'd0);
    chk("byp_fall_ev", 64'(bus.event_o), 64'd0);
    bus.edge_mode_i[0] = 2'b00;
    bus.irq_mask_i     = '0;

    // Debounce D=5 on pad 3: 4-cycle glitch rejected, 5-cycle level accepted
    bus.filt_en_i[3]   = 1'b1;
    bus.debounce_len_i = 8'd5;
    bus.io_in_i[3]     = 1'b1;
    tick(4);
    bus.io_in_i[3] = 1'b0;
    tick(8);
    chk("deb_glitch", 64'(bus.io_in_o), 64'd0);
    bus.io_in_i[3] = 1'b1;
    tick(6);
    chk("deb_c6", 64'(bus.io_in_o), 64'd0);
    tick(1);
    chk("deb_c7", 64'(bus.io_in_o), 64'(B3));
    bus.io_in_i[3] = 1'b0;
    tick(6);
    chk("deb_fall_c6", 64'(bus.io_in_o), 64'(B3));
    tick(1);
    chk("deb_fall_c7", 64'(bus.io_in_o), 64'd0);
    bus.io_in_i[3] = 1'b1;
    tick(7);
    chk("deb_rehigh", 64'(bus.io_in_o), 64'(B3));

    // Edge modes on pad 7 (bypass)
    bus.edge_mode_i[7] = 2'b01;
    bus.io_in_i[7] = 1'b1;
    tick(4);
    chk("m01_rise", 64'(bus.event_o), 64'(B7));
    bus.io_in_i[7] = 1'b0;
    tick(4);
    chk("m01_fall", 64'(bus.event_o), 64'(B7));
    bus.event_clr_i[7] = 1'b1;
    tick(1);
    bus.event_clr_i[7] = 1'b0;
    chk("m01_clr", 64'(bus.event_o), 64'd0);
    bus.edge_mode_i[7] = 2'b10;
    bus.io_in_i[7] = 1'b1;
    tick(4);
    chk("m10_rise", 64'(bus.event_o), 64'd0);
    bus.io_in_i[7] = 1'b0;
    tick(4);
    chk("m10_fall", 64'(bus.event_o), 64'(B7));
    bus.event_clr_i[7] = 1'b1;
    tick(1);
    bus.event_clr_i[7] = 1'b0;
    bus.edge_mode_i[7] = 2'b11;
    bus.io_in_i[7] = 1'b1;
    tick(4);
    chk("m11_rise", 64'(bus.event_o), 64'(B7));
    bus.event_clr_i[7] = 1'b1;
    tick(1);
    bus.event_clr_i[7] = 1'b0;
    chk("m11_clr", 64'(bus.event_o), 64'd0);
    bus.io_in_i[7] = 1'b0;
    tick(4);
    chk("m11_fall", 64'(bus.event_o), 64'(B7));
    bus.event_clr_i[7] = 1'b1;
    tick(1);
    bus.event_clr_i[7] = 1'b0;
    bus.edge_mode_i[7] = 2'b00;
    bus.io_in_i[7] = 1'b1;
    tick(4);
    bus.io_in_i[7] = 1'b0;
    tick(4);
    chk("m00_none", 64'(bus.event_o), 64'd0);

    // Set/clear collision on pad 5
    bus.edge_mode_i[5] = 2'b01;
    bus.io_in_i[5] = 1'b1;
    tick(3);
    bus.event_clr_i[5] = 1'b1;
    tick(1);
    chk("coll_set_wins", 64'(bus.event_o), 64'(B5));
    tick(1);
    bus.event_clr_i[5] = 1'b0;
    chk("coll_clr_alone", 64'(bus.event_o), 64'd0);

    // Multi-channel with irq mask on pad 30 only
    bus.edge_mode_i[0]  = 2'b01;
    bus.edge_mode_i[30] = 2'b01;
    bus.edge_mode_i[60] = 2'b01;
    bus.irq_mask_i = B30;
    bus.io_in_i[0]  = 1'b1;
    bus.io_in_i[30] = 1'b1;
    bus.io_in_i[60] = 1'b1;
    tick(3);
    chk("multi_irq_pre", 64'(bus.irq_o), 64'd0);
    tick(1);
    chk("multi_ev",  64'(bus.event_o), 64'(B0 | B30 | B60));
    chk("multi_irq", 64'(bus.irq_o),   64'd1);
    bus.event_clr_i[30] = 1'b1;
    tick(1);
    bus.event_clr_i[30] = 1'b0;
    chk("multi_clr30_ev",  64'(bus.event_o), 64'(B0 | B60));
    chk("multi_clr30_irq", 64'(bus.irq_o),   64'd0);
    bus.irq_mask_i = B0;
    tick(1);
    chk("mask0_irq", 64'(bus.irq_o),   64'd1);
    bus.irq_mask_i = '0;
    tick(1);
    chk("unmask_irq", 64'(bus.irq_o),   64'd0);
    chk("unmask_ev",  64'(bus.event_o), 64'(B0 | B60));

    // Reset mid-count with D=200 on pad 3
    bus.irq_mask_i     = B0;
    bus.debounce_len_i = 8'd200;
    bus.io_in_i[3]     = 1'b0;
    tick(102);
    chk("mid_io",  64'(bus.io_in_o), 64'(B0 | B3 | B5 | B30 | B60));
    chk("mid_irq", 64'(bus.irq_o),   64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_io",  64'(bus.io_in_o), 64'd0);
    chk("arst_ev",  64'(bus.event_o), 64'd0);
    chk("arst_irq", 64'(bus.irq_o),   64'd0);
    tick(1);
    rst_n = 1'b1;
    bus.io_in_i[3] = 1'b1;
    tick(4);
    chk("post_ev",  64'(bus.event_o), 64'(B0 | B5 | B30 | B60));
    chk("post_irq", 64'(bus.irq_o),   64'd1);
    tick(197);
    chk("post_c201", 64'(bus.io_in_o[3]), 64'd0);
    tick(1);
    chk("post_c202", 64'(bus.io_in_o[3]), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
